// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P type definitions for the channel-1 write path.
// Only the types that the Tx c1 buffer needs are defined here.
package ccip_if_pkg;

   typedef logic [511:0] t_ccip_clData;
   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;

   typedef struct packed {
      logic [5:0]   rsvd2;
      logic [1:0]   vc_sel;
      logic         sop;
      logic         rsvd1;
      logic [1:0]   cl_len;
      logic [3:0]   req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

endpackage

// File: rtl/ccip_sync_fifo.sv
// Single-clock FIFO with pointer, occupancy and full/empty tracking.
// Storage is not reset; only pointers and count are.
module ccip_sync_fifo #(
   parameter int unsigned WIDTH      = 592,
   parameter int unsigned DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  push_ok, pop_ok;

   always_comb begin
      full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
      empty   = (count_q == '0);
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ccip_c1_tx_buffer.sv
// Elastic buffer for CCI-P Tx c1 write requests: FIFO, registered output
// gated by c1TxAlmFull, plus overflow flag and stall counter for debug.
module ccip_c1_tx_buffer
   import ccip_if_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 5,
   parameter int unsigned STALL_CNT_W = 32
) (
   input  logic                                  pClk,
   input  logic                                  pck_cp2af_softReset_n,
   input  logic                                  in_valid,
   input  logic [$bits(t_ccip_c1_ReqMemHdr)-1:0] in_hdr,
   input  logic [$bits(t_ccip_clData)-1:0]       in_data,
   output logic                                  in_ready,
   input  logic                                  c1TxAlmFull,
   output logic                                  out_valid,
   output logic [$bits(t_ccip_c1_ReqMemHdr)-1:0] out_hdr,
   output logic [$bits(t_ccip_clData)-1:0]       out_data,
   output logic [DEPTH_LOG2:0]                   count,
   output logic                                  overflow_err,
   output logic [STALL_CNT_W-1:0]                stall_cycles
);

   localparam int unsigned HDR_W = $bits(t_ccip_c1_ReqMemHdr);
   localparam int unsigned DAT_W = $bits(t_ccip_clData);

   logic                   push, pop, full, empty;
   logic [HDR_W+DAT_W-1:0] head;

   logic                   out_valid_q, out_valid_d;
   logic [HDR_W-1:0]       out_hdr_q, out_hdr_d;
   logic [DAT_W-1:0]       out_data_q, out_data_d;
   logic                   overflow_q, overflow_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   ccip_sync_fifo #(
      .WIDTH      (HDR_W + DAT_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (pClk),
      .rst_n (pck_cp2af_softReset_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_hdr, in_data}),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Almost-full is honoured immediately: no request issues once it is sampled high.
   always_comb begin
      in_ready    = !full;
      push        = in_valid && in_ready;
      pop         = !empty && !c1TxAlmFull;
      out_valid_d = pop;
      out_hdr_d   = out_hdr_q;
      out_data_d  = out_data_q;
      if (pop) {out_hdr_d, out_data_d} = head;
      overflow_d  = overflow_q || (in_valid && !in_ready);
      stall_d     = stall_q;
      if (!empty && c1TxAlmFull && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         out_valid_q <= 1'b0;
         out_hdr_q   <= '0;
         out_data_q  <= '0;
         overflow_q  <= 1'b0;
         stall_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_hdr_q   <= out_hdr_d;
         out_data_q  <= out_data_d;
         overflow_q  <= overflow_d;
         stall_q     <= stall_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_hdr      = out_hdr_q;
   assign out_data     = out_data_q;
   assign overflow_err = overflow_q;
   assign stall_cycles = stall_q;

endmodule
